// File: rtl/carfield_mbox_responder.sv
// Security-island mailbox responder.
// The host sees a small register window on a request/grant bus. The island
// feeds an inbound FIFO, which the host pops through RDATA. The host writes
// one outbound word for the island through WDATA. A level interrupt tells the
// host when enough inbound messages are waiting.
//
// Handshake semantics:
//   Register bus: a request is granted in the same cycle req_i is high
//   (gnt_o == req_i). All side effects happen in that accept cycle. The
//   response (rvalid_o, rdata_o, err_o) is registered and shows up exactly
//   one cycle later, for one cycle.
//   Inbound stream: a word transfers on a clock edge where in_valid_i and
//   in_ready_o are both high. in_ready_o depends only on registered state.
//   Outbound stream: a word transfers on a clock edge where out_valid_o and
//   out_ready_i are both high. out_valid_o drops on the following cycle.
module carfield_mbox_responder #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned InDepth   = 8,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // register request bus
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    // inbound messages from the island
    input  logic                 in_valid_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 in_ready_o,
    // outbound word to the island
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 out_ready_i,
    // interrupt to the host
    output logic                 irq_o
);

    localparam int unsigned PtrWidth  = $clog2(InDepth);
    localparam int unsigned CntWidth  = $clog2(InDepth + 1);
    localparam int unsigned IdxWidth  = AddrWidth - 2;

    localparam logic [CntWidth-1:0] FullCount = CntWidth'(InDepth);

    // Word indices of the registers inside the window.
    localparam logic [IdxWidth-1:0] IdxRdata  = IdxWidth'(0);
    localparam logic [IdxWidth-1:0] IdxWdata  = IdxWidth'(1);
    localparam logic [IdxWidth-1:0] IdxStatus = IdxWidth'(2);
    localparam logic [IdxWidth-1:0] IdxCtrl   = IdxWidth'(3);
    localparam logic [IdxWidth-1:0] IdxThresh = IdxWidth'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] fifoMem [InDepth];
    logic [PtrWidth-1:0]  rdPtr;
    logic [PtrWidth-1:0]  wrPtr;
    logic [CntWidth-1:0]  inCount;

    logic                 irqEn;
    logic [7:0]           thresh;
    logic                 stickyErr;

    logic                 outValid;
    logic [DataWidth-1:0] outData;

    logic                 respValid;
    logic [DataWidth-1:0] respDataQ;
    logic                 respErrQ;
    logic                 irqQ;

    // ------------------------------------------------------------------
    // Decode and next-state signals
    // ------------------------------------------------------------------
    logic [IdxWidth-1:0]  wordIdx;
    logic                 inEmpty;
    logic                 inFull;
    logic                 doPush;
    logic                 doPop;
    logic                 doFlush;
    logic                 setSticky;
    logic                 clrSticky;
    logic                 wrOut;
    logic                 wrCtrl;
    logic                 wrThresh;
    logic                 respErr;
    logic [DataWidth-1:0] respData;
    logic [DataWidth-1:0] statusWord;
    logic [CntWidth-1:0]  countNext;
    logic                 irqNext;

    // Byte-lane bits of the address never select anything.
    logic unusedAddrBits;
    assign unusedAddrBits = ^addr_i[1:0];

    assign wordIdx = addr_i[AddrWidth-1:2];
    assign inEmpty = (inCount == '0);
    assign inFull  = (inCount == FullCount);

    // Inbound acceptance is decided from registered fullness only.
    assign doPush = in_valid_i & ~inFull;

    // Status register image, built from registered state.
    always_comb begin
        statusWord       = '0;
        statusWord[0]    = inEmpty;
        statusWord[1]    = inFull;
        statusWord[2]    = outValid;
        statusWord[3]    = stickyErr;
        statusWord[15:8] = 8'(inCount);
    end

    // Register access decode: response data/error and side-effect strobes.
    always_comb begin
        respErr   = 1'b0;
        respData  = '0;
        doPop     = 1'b0;
        doFlush   = 1'b0;
        setSticky = 1'b0;
        clrSticky = 1'b0;
        wrOut     = 1'b0;
        wrCtrl    = 1'b0;
        wrThresh  = 1'b0;
        if (req_i) begin
            case (wordIdx)
                IdxRdata: begin
                    if (we_i) begin
                        respErr = 1'b1;
                    end else if (inEmpty) begin
                        // Popping an empty FIFO is a host protocol error.
                        respErr   = 1'b1;
                        setSticky = 1'b1;
                    end else begin
                        respData = fifoMem[rdPtr];
                        doPop    = 1'b1;
                    end
                end
                IdxWdata: begin
                    if (!we_i) begin
                        respErr = 1'b1;
                    end else if (outValid) begin
                        // Overwriting an unconsumed word is refused even if
                        // the island takes it in this very cycle.
                        respErr   = 1'b1;
                        setSticky = 1'b1;
                    end else begin
                        wrOut = 1'b1;
                    end
                end
                IdxStatus: begin
                    if (we_i) begin
                        respErr = 1'b1;
                    end else begin
                        respData = statusWord;
                    end
                end
                IdxCtrl: begin
                    if (we_i) begin
                        wrCtrl    = 1'b1;
                        clrSticky = wdata_i[1];
                        doFlush   = wdata_i[2];
                    end else begin
                        respData[0] = irqEn;
                    end
                end
                IdxThresh: begin
                    if (we_i) begin
                        wrThresh = 1'b1;
                    end else begin
                        respData[7:0] = thresh;
                    end
                end
                default: begin
                    respErr = 1'b1;
                end
            endcase
        end
    end

    // Occupancy after this cycle's push/pop/flush; a flush discards any push.
    always_comb begin
        countNext = inCount;
        if (doFlush) begin
            countNext = '0;
        end else begin
            case ({doPush, doPop})
                2'b10:   countNext = inCount + CntWidth'(1);
                2'b01:   countNext = inCount - CntWidth'(1);
                default: countNext = inCount;
            endcase
        end
    end

    // Interrupt condition evaluated on the occupancy the FIFO is about to hold.
    always_comb begin
        irqNext = irqEn & (thresh != 8'd0) & (9'(countNext) >= 9'(thresh));
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (doPush && !doFlush) begin
            fifoMem[wrPtr] <= in_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            inCount <= '0;
        end else begin
            inCount <= countNext;
            if (doFlush) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (doPush) begin
                    wrPtr <= wrPtr + PtrWidth'(1);
                end
                if (doPop) begin
                    rdPtr <= rdPtr + PtrWidth'(1);
                end
            end
        end
    end

    // Control registers: irq enable, threshold, and sticky error (clear wins).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irqEn     <= 1'b0;
            thresh    <= 8'd0;
            stickyErr <= 1'b0;
        end else begin
            if (wrCtrl) begin
                irqEn <= wdata_i[0];
            end
            if (wrThresh) begin
                thresh <= wdata_i[7:0];
            end
            if (clrSticky) begin
                stickyErr <= 1'b0;
            end else if (setSticky) begin
                stickyErr <= 1'b1;
            end
        end
    end

    // Outbound word holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else begin
            if (wrOut) begin
                outValid <= 1'b1;
                outData  <= wdata_i;
            end else if (outValid && out_ready_i) begin
                outValid <= 1'b0;
            end
        end
    end

    // One-cycle-delayed bus response and registered interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            respValid <= 1'b0;
            respDataQ <= '0;
            respErrQ  <= 1'b0;
            irqQ      <= 1'b0;
        end else begin
            respValid <= req_i;
            respDataQ <= respData;
            respErrQ  <= respErr;
            irqQ      <= irqNext;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt_o       = req_i;
    assign rvalid_o    = respValid;
    assign rdata_o     = respDataQ;
    assign err_o       = respErrQ;
    assign in_ready_o  = ~inFull;
    assign out_valid_o = outValid;
    assign out_data_o  = outData;
    assign irq_o       = irqQ;

endmodule

// File: doc/carfield_mbox_responder.md
Name: carfield_mbox_responder

Overview:
- Memory-mapped responder for the security-island mailbox window (base 0x4000_0000, 4 KiB). The host drives accesses into it, converted to a simple register request bus.
- Buffers inbound messages from the security island in a FIFO, which the host pops through a register.
- Forwards one host-written outbound word to the island.
- Drives the level-sensitive mailbox external interrupt to the host.

Parameters:
- DataWidth, 32, register/message width.
- InDepth, 8, inbound FIFO entries (power of two, 2..128).
- AddrWidth, 12, byte-address width within the window.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  bus request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AddrWidth  byte address; bits [1:0] ignored
- wdata_i  in  DataWidth  write data
- gnt_o  out  1  grant; combinationally equal to req_i
- rvalid_o  out  1  response valid
- rdata_o  out  DataWidth  read data
- err_o  out  1  response error
- in_valid_i  in  1  inbound message valid
- in_data_i  in  DataWidth  inbound message
- in_ready_o  out  1  inbound accept, equal to !in_full
- out_valid_o  out  1  outbound word pending
- out_data_o  out  DataWidth  outbound word
- out_ready_i  in  1  island consumes outbound word
- irq_o  out  1  interrupt to host, registered

Behaviour:
- Reset values (rst_i async, active-high): rvalid_o=0, rdata_o=0, err_o=0, out_valid_o=0, out_data_o=0, irq_o=0. FIFO empty, so in_ready_o=1. ctrl=0, thresh=0, sticky error=0.
- Bus: each request is accepted in the cycle req_i=1. The response comes exactly one cycle later: rvalid_o=1 for one cycle with rdata_o/err_o. Back-to-back requests are allowed every cycle. Write responses return rdata_o=0.
- Register map (word offsets):
  - 0x00 RDATA, RO. A read pops the FIFO head and returns it. If the FIFO is empty, the read returns 0 with err_o=1, sets the sticky error, and pops nothing.
  - 0x04 WDATA, WO. A write loads out_data_o and sets out_valid_o. If out_valid_o is already 1 (registered value, even when out_ready_i=1 that cycle), the write returns err_o=1, sets the sticky error, and leaves the word unchanged.
  - 0x08 STATUS, RO: [0] in_empty, [1] in_full, [2] out_valid_o, [3] sticky error, [15:8] in_count (zero-extended). All other bits 0.
  - 0x0C CTRL, RW: [0] irq_en is stored. [1] write 1 clears the sticky error; reads 0. [2] write 1 flushes the FIFO; self-clearing, reads 0.
  - 0x10 THRESH, RW: [7:0] stored, other bits read 0.
  - Any other offset: err_o=1, rdata_o=0, no side effects. The sticky error is not set.
  - Write to a RO register or read of a WO register: err_o=1, no side effects. The sticky error is not set.
- Inbound FIFO: a push happens when in_valid_i & in_ready_o. in_ready_o depends only on registered full, so when full a same-cycle pop does not admit a push. A simultaneous push and pop on a non-full, non-empty FIFO leaves in_count unchanged. Read and write pointers wrap modulo InDepth. in_count width is clog2(InDepth+1).
- Empty FIFO with a same-cycle push and RDATA read: the read errors and the pushed word is stored.
- Flush: in_count becomes 0 next cycle. A push in the same cycle is discarded, even though it was accepted.
- Outbound: out_valid_o clears the cycle after out_valid_o & out_ready_i. A WDATA write in the same cycle as that handshake still errors, per the rule above.
- irq_o next value = irq_en & (thresh!=0) & (in_count_next >= thresh). It is level-sensitive and drops once pops bring the count below thresh.
- A sticky-error set and a CTRL clear in the same cycle: clear wins.

Test Plan:
- Reset → irq_o=0, in_ready_o=1, out_valid_o=0. Read STATUS → 0x0000_0001.
- Push 0xA, 0xB, 0xC inbound, then read 0x00 three times → 0xA, 0xB, 0xC with err_o=0. A fourth read → rdata 0, err_o=1, STATUS[3]=1. Write CTRL=0x2 → STATUS[3]=0.
- Push 8 words → in_ready_o=0 and STATUS=0x0000_0802. Hold in_valid_i=1 while reading RDATA → the next push is accepted only the cycle after the pop. Continue pushing 9 more while popping, wrapping the pointers → order preserved.
- Write THRESH=3, CTRL=1, push 3 words → irq_o=1 the cycle after the 3rd push. Pop one → irq_o=0 the cycle after the pop.
- Write WDATA=0x1234, out_ready_i=0 → out_valid_o=1, out_data_o=0x1234. A second write of 0x5678 → err_o=1, data unchanged. Assert out_ready_i → out_valid_o=0 next cycle.
- Push 5 words, write CTRL=0x4 with a concurrent push → in_count=0 next cycle. Read offset 0x20 → err_o=1, STATUS[3] unchanged. Assert rst_i mid-transfer → all outputs return to reset values asynchronously.
